// File: rtl/rl_cell_pair_scheduler_pkg.sv
// Shared RL constants and the cell-pair scheduler state encoding,
// also used by the top-level RL controller.
package rl_cell_pair_scheduler_pkg;

  localparam int RL_NUM_NB_CELL  = 14;
  localparam int RL_DRAIN_CYCLES = 31;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } rl_state_t;

endpackage

// File: rtl/rl_cell_pair_scheduler.sv
// Sweeps every (home particle, neighbor particle) pair over the neighbor-cell slots,
// issuing one position-RAM read per cycle; stalls on filter back-pressure.
module rl_cell_pair_scheduler
  import rl_cell_pair_scheduler_pkg::*;
#(
  parameter int NUM_FILTER     = 4,
  parameter int NUM_NB_CELL    = RL_NUM_NB_CELL,
  parameter int ADDR_WIDTH     = 7,
  parameter int CELL_SEL_WIDTH = 4,
  parameter int DRAIN_CYCLES   = RL_DRAIN_CYCLES,
  parameter int CNT_WIDTH      = 24
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [ADDR_WIDTH:0]                  home_count,
  input  logic [NUM_NB_CELL*(ADDR_WIDTH+1)-1:0] nb_count,
  input  logic [NUM_FILTER-1:0]                back_pressure,
  output logic                                 rden,
  output logic [ADDR_WIDTH-1:0]                home_rdaddr,
  output logic [CELL_SEL_WIDTH-1:0]            nb_cell_sel,
  output logic [ADDR_WIDTH-1:0]                nb_rdaddr,
  output logic                                 input_valid,
  output logic [ADDR_WIDTH-1:0]                ref_particle_id,
  output logic [CELL_SEL_WIDTH+ADDR_WIDTH-1:0] neighbor_particle_id,
  output logic                                 busy,
  output logic                                 done,
  output logic [CNT_WIDTH-1:0]                 pair_count
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  rl_state_t                      state;
  logic [CELL_SEL_WIDTH-1:0]      cell_ptr;
  logic [ADDR_WIDTH-1:0]          home_ptr;
  logic [ADDR_WIDTH-1:0]          nb_ptr;
  logic [CW-1:0]                  home_q;
  logic [NUM_NB_CELL*CW-1:0]      nb_q;
  logic [DW-1:0]                  drain_cnt;

  logic [CW-1:0] cur_cnt;
  logic          last_nb;
  logic          last_home;
  logic          last_cell;

  // Particle count of the slot currently being swept, from the latched copy.
  always_comb begin
    cur_cnt = '0;
    for (int k = 0; k < NUM_NB_CELL; k++) begin
      if (cell_ptr == CELL_SEL_WIDTH'(k)) cur_cnt = nb_q[k*CW +: CW];
    end
  end

  assign last_nb   = (({1'b0, nb_ptr} + CW'(1)) == cur_cnt);
  assign last_home = (({1'b0, home_ptr} + CW'(1)) == home_q);
  assign last_cell = (cell_ptr == CELL_SEL_WIDTH'(NUM_NB_CELL - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= ST_IDLE;
      cell_ptr             <= '0;
      home_ptr             <= '0;
      nb_ptr               <= '0;
      home_q               <= '0;
      nb_q                 <= '0;
      drain_cnt            <= '0;
      rden                 <= 1'b0;
      home_rdaddr          <= '0;
      nb_cell_sel          <= '0;
      nb_rdaddr            <= '0;
      input_valid          <= 1'b0;
      ref_particle_id      <= '0;
      neighbor_particle_id <= '0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      pair_count           <= '0;
    end else begin
      // Read data returns one cycle after rden; IDs travel with it.
      input_valid          <= rden;
      ref_particle_id      <= home_rdaddr;
      neighbor_particle_id <= {nb_cell_sel, nb_rdaddr};
      rden                 <= 1'b0;
      done                 <= 1'b0;

      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              state <= ST_LOAD;
              busy  <= 1'b1;
            end
          end

          ST_LOAD: begin
            home_q     <= home_count;
            nb_q       <= nb_count;
            pair_count <= '0;
            cell_ptr   <= '0;
            home_ptr   <= '0;
            nb_ptr     <= '0;
            drain_cnt  <= '0;
            if (home_count == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end

          ST_RUN: begin
            if (back_pressure == '0) begin
              if (cur_cnt == '0) begin
                // Empty slot costs exactly one idle cycle.
                home_ptr <= '0;
                nb_ptr   <= '0;
                if (last_cell) state <= ST_DRAIN;
                else           cell_ptr <= cell_ptr + CELL_SEL_WIDTH'(1);
              end else begin
                rden        <= 1'b1;
                home_rdaddr <= home_ptr;
                nb_cell_sel <= cell_ptr;
                nb_rdaddr   <= nb_ptr;
                pair_count  <= pair_count + CNT_WIDTH'(1);
                if (!last_nb) begin
                  nb_ptr <= nb_ptr + ADDR_WIDTH'(1);
                end else begin
                  nb_ptr <= '0;
                  if (!last_home) begin
                    home_ptr <= home_ptr + ADDR_WIDTH'(1);
                  end else begin
                    home_ptr <= '0;
                    if (last_cell) state <= ST_DRAIN;
                    else           cell_ptr <= cell_ptr + CELL_SEL_WIDTH'(1);
                  end
                end
              end
            end
          end

          ST_DRAIN: begin
            if (drain_cnt == DW'(DRAIN_CYCLES - 1)) begin
              drain_cnt <= '0;
              state     <= ST_DONE;
              done      <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end

          ST_DONE: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rl_cell_pair_scheduler.sv
// Bench for rl_cell_pair_scheduler: vector table with a pair scoreboard,
// plus abort and asynchronous-reset sequences.
module tb_rl_cell_pair_scheduler;

  localparam int NF   = 4;
  localparam int NB   = 14;
  localparam int AW   = 7;
  localparam int CSW  = 4;
  localparam int DC   = 31;
  localparam int CNTW = 24;
  localparam int CW   = AW + 1;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                start = 1'b0;
  logic                abort = 1'b0;
  logic [CW-1:0]       home_count = '0;
  logic [NB*CW-1:0]    nb_count = '0;
  logic [NF-1:0]       back_pressure = '0;
  logic                rden;
  logic [AW-1:0]       home_rdaddr;
  logic [CSW-1:0]      nb_cell_sel;
  logic [AW-1:0]       nb_rdaddr;
  logic                input_valid;
  logic [AW-1:0]       ref_particle_id;
  logic [CSW+AW-1:0]   neighbor_particle_id;
  logic                busy;
  logic                done;
  logic [CNTW-1:0]     pair_count;

  rl_cell_pair_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .abort                (abort),
    .home_count           (home_count),
    .nb_count             (nb_count),
    .back_pressure        (back_pressure),
    .rden                 (rden),
    .home_rdaddr          (home_rdaddr),
    .nb_cell_sel          (nb_cell_sel),
    .nb_rdaddr            (nb_rdaddr),
    .input_valid          (input_valid),
    .ref_particle_id      (ref_particle_id),
    .neighbor_particle_id (neighbor_particle_id),
    .busy                 (busy),
    .done                 (done),
    .pair_count           (pair_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              home;
    logic [NB*CW-1:0] nbc;
    int              bp_at;
    int              bp_len;
    logic [NF-1:0]   bp_mask;
    int              exp_pairs;
    int              exp_lows;
  } vec_t;

  typedef struct {
    logic [AW-1:0]     ref_id;
    logic [CSW+AW-1:0] nb_id;
  } pair_t;

  pair_t sb[$];
  vec_t  tbl[7];
  int    n_vec  = 0;
  int    n_fail = 0;

  logic              prev_rden = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [NB*CW-1:0] slots(input int c0, input int c1, input int c2,
                                             input int c3, input int c13);
    logic [NB*CW-1:0] r;
    r = '0;
    r[0*CW +: CW]  = CW'(c0);
    r[1*CW +: CW]  = CW'(c1);
    r[2*CW +: CW]  = CW'(c2);
    r[3*CW +: CW]  = CW'(c3);
    r[13*CW +: CW] = CW'(c13);
    return r;
  endfunction

  // Monitor: input_valid trails rden by one cycle and returns pairs in sweep order.
  always @(negedge clk) begin
    if (!rst) begin
      prev_rden = 1'b0;
    end else begin
      chk("ivalid_trail", 64'(input_valid), 64'(prev_rden));
      if (input_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_pair", 64'(1), 64'(0));
        end else begin
          pair_t p;
          p = sb.pop_front();
          chk("ref_id", 64'(ref_particle_id), 64'(p.ref_id));
          chk("nb_id", 64'(neighbor_particle_id), 64'(p.nb_id));
        end
      end
      prev_rden = rden;
    end
  end

  // Push the expected pair stream; return RUN-cycle count and the last pair.
  task automatic model(input vec_t v, output int r_cyc, output pair_t last);
    pair_t p;
    r_cyc = 0;
    last.ref_id = '0;
    last.nb_id  = '0;
    for (int s = 0; s < NB; s++) begin
      int cnt;
      cnt = int'(v.nbc[s*CW +: CW]);
      if (cnt == 0) r_cyc++;
      else r_cyc += v.home * cnt;
      for (int h = 0; h < v.home; h++) begin
        for (int n = 0; n < cnt; n++) begin
          p.ref_id = AW'(h);
          p.nb_id  = {CSW'(s), AW'(n)};
          sb.push_back(p);
          last = p;
        end
      end
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int    r_cyc, exp_done, rden_n, pend, lows, bp_left, done_cyc;
    bit    seen_first;
    pair_t last;
    model(v, r_cyc, last);
    exp_done = (v.home == 0) ? 2 : r_cyc + v.bp_len + 2 + DC;
    home_count = CW'(v.home);
    nb_count   = v.nbc;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    rden_n = 0; pend = 0; lows = 0; bp_left = 0; done_cyc = -1; seen_first = 0;
    chk({nm, " busy_load"}, 64'(busy), 64'(1));
    for (int c = 1; c < 600 && done_cyc < 0; c++) begin
      if (c == 2) begin
        // Counts are latched by now; scramble the live inputs.
        home_count = CW'($urandom_range(1, 255));
        for (int k = 0; k < NB; k++) nb_count[k*CW +: CW] = CW'($urandom_range(1, 255));
      end
      start = (c == 4 && v.home != 0);
      if (rden) begin
        rden_n++;
        if (seen_first) lows += pend;
        pend = 0;
        seen_first = 1;
        if (rden_n == v.bp_at) bp_left = v.bp_len;
      end else if (seen_first) begin
        pend++;
      end
      if (bp_left > 0) begin
        back_pressure = v.bp_mask;
        bp_left--;
      end else begin
        back_pressure = '0;
      end
      if (done) done_cyc = c;
      else begin
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    back_pressure = '0;
    chk({nm, " done_seen"}, 64'(done_cyc >= 0), 64'(1));
    chk({nm, " done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({nm, " rden_cycles"}, 64'(rden_n), 64'(v.exp_pairs));
    chk({nm, " pair_count"}, 64'(pair_count), 64'(v.exp_pairs));
    chk({nm, " idle_gaps"}, 64'(lows), 64'(v.exp_lows));
    if (v.exp_pairs > 0) begin
      chk({nm, " hold_home"}, 64'(home_rdaddr), 64'(last.ref_id));
      chk({nm, " hold_nb"}, 64'({nb_cell_sel, nb_rdaddr}), 64'(last.nb_id));
    end
    @(posedge clk); #1;
    chk({nm, " done_pulse"}, 64'(done), 64'(0));
    chk({nm, " busy_idle"}, 64'(busy), 64'(0));
    chk({nm, " sb_empty"}, 64'(sb.size()), 64'(0));
  endtask

  initial begin
    int    r_cyc;
    pair_t last;

    tbl[0] = '{2,   slots(3, 0, 0, 0, 0), 0, 0, 4'b0000, 6,   0};
    tbl[1] = '{2,   slots(3, 0, 0, 0, 0), 2, 3, 4'b0010, 6,   3};
    tbl[2] = '{0,   slots(3, 0, 0, 0, 0), 0, 0, 4'b0000, 0,   0};
    tbl[3] = '{1,   slots(1, 0, 1, 0, 0), 0, 0, 4'b0000, 2,   1};
    tbl[4] = '{3,   slots(2, 0, 0, 1, 2), 4, 1, 4'b1000, 15,  12};
    tbl[5] = '{1,   slots(0, 0, 0, 0, 1), 0, 0, 4'b0000, 1,   0};
    tbl[6] = '{128, slots(1, 0, 0, 0, 0), 0, 0, 4'b0000, 128, 0};

    #12;
    chk("rst_rden", 64'(rden), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ivalid", 64'(input_valid), 64'(0));
    chk("rst_pair_count", 64'(pair_count), 64'(0));
    chk("rst_addr", 64'({home_rdaddr, nb_cell_sel, nb_rdaddr}), 64'(0));
    chk("rst_ids", 64'({ref_particle_id, neighbor_particle_id}), 64'(0));
    #11 rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

    // Abort on the 4th RUN cycle, with start raised alongside it.
    model(tbl[0], r_cyc, last);
    home_count = 2;
    nb_count   = slots(3, 0, 0, 0, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_rden", 64'(rden), 64'(0));
    chk("abort_done", 64'(done), 64'(0));
    chk("abort_pair_count", 64'(pair_count), 64'(3));
    @(negedge clk); #1;
    chk("abort_sb_left", 64'(sb.size()), 64'(3));
    sb.delete();
    run_vec("after_abort", tbl[0]);

    // Asynchronous reset mid-RUN, between clock edges.
    model(tbl[0], r_cyc, last);
    home_count = 2;
    nb_count   = slots(3, 0, 0, 0, 0);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("pre_rst_rden", 64'(rden), 64'(1));
    #2 rst = 1'b0;
    #1;
    chk("async_rst_rden", 64'(rden), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    chk("async_rst_ivalid", 64'(input_valid), 64'(0));
    chk("async_rst_pair_count", 64'(pair_count), 64'(0));
    sb.delete();
    @(posedge clk); #3 rst = 1'b1;
    run_vec("after_rst", tbl[3]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
